// File: rtl/fetch_irq_ctrl.sv
// IF-stage sequencer: merges the stall sources and turns external interrupts into a
// one-cycle InterruptHandled/Flush pulse that never lands on a delay slot. Optional macro: FETCH_CTRL_PERF_EN.
module fetch_irq_ctrl #(
    parameter int NUM_IRQ     = 4,
    parameter int STALL_CNT_W = 32
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   ICacheMiss,
    input  logic                   DCacheMiss,
    input  logic                   LoadUse,
    input  logic                   BranchOrJump_E,
    input  logic [31:0]            PC_I,
    input  logic [NUM_IRQ-1:0]     IrqReq,
    input  logic [NUM_IRQ-1:0]     IrqMask,
    input  logic                   IE,
    input  logic                   Eret,
    output logic                   Stall,
    output logic                   InterruptHandled,
    output logic                   Flush,
    output logic [31:0]            EPC,
    output logic [NUM_IRQ-1:0]     IrqCause,
    output logic                   InHandler,
    output logic [STALL_CNT_W-1:0] StallCycles,
    output logic [1:0]             DbgState
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_SLOT = 2'd1,
        TAKE      = 2'd2,
        HANDLER   = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic                 w_pending;
    logic                 w_capture;
    logic                 w_take_now;
    logic                 w_eret_ok;
    logic [31:0]          r_epc;
    logic [NUM_IRQ-1:0]   r_irq_cause;
    logic                 r_in_handler;

    assign Stall     = ICacheMiss | DCacheMiss | LoadUse;
    assign w_pending = IE & (|(IrqReq & IrqMask));

    always_comb begin
        w_next_state = r_state;
        w_capture    = 1'b0;
        w_take_now   = 1'b0;
        w_eret_ok    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pending) begin
                    w_capture    = 1'b1;
                    w_next_state = BranchOrJump_E ? WAIT_SLOT : TAKE;
                end
            end
            WAIT_SLOT: begin
                if (!Stall) begin
                    w_next_state = TAKE;
                end
            end
            TAKE: begin
                if (!Stall) begin
                    w_take_now   = 1'b1;
                    w_next_state = HANDLER;
                end
            end
            HANDLER: begin
                if (Eret && !Stall) begin
                    w_eret_ok    = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Pulse semantics: InterruptHandled/Flush are high for exactly the one cycle in which
    // the pipeline advances out of TAKE; they never coincide with Stall or with Reset.
    assign InterruptHandled = w_take_now & ~Reset;
    assign Flush            = w_take_now & ~Reset;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state      <= IDLE;
            r_epc        <= 32'd0;
            r_irq_cause  <= '0;
            r_in_handler <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_capture) begin
                r_irq_cause <= IrqReq & IrqMask;
            end
            if (w_take_now) begin
                r_epc        <= PC_I;
                r_in_handler <= 1'b1;
            end
            if (w_eret_ok) begin
                r_in_handler <= 1'b0;
            end
        end
    end

    assign EPC       = r_epc;
    assign IrqCause  = r_irq_cause;
    assign InHandler = r_in_handler;
    assign DbgState  = r_state;

`ifdef FETCH_CTRL_PERF_EN
    logic [STALL_CNT_W-1:0] r_stall_cycles;

    // Saturating so a long run never wraps back to a misleadingly small count.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_stall_cycles <= '0;
        end else if (Stall && (r_stall_cycles != {STALL_CNT_W{1'b1}})) begin
            r_stall_cycles <= r_stall_cycles + STALL_CNT_W'(1);
        end
    end

    assign StallCycles = r_stall_cycles;
`else
    assign StallCycles = '0;
`endif

endmodule

// File: tb/tb_fetch_irq_ctrl.sv
// Randomized bench for fetch_irq_ctrl: an interrupt-lifecycle model predicts per-cycle outputs
// and pulse events into queues; an independent monitor pops and compares at the falling edge.
module tb_fetch_irq_ctrl;
    localparam int NI = 4;
    localparam int CW = 4;
    localparam int EW = 16 + 3 + 32 + NI + CW;
    localparam int PW = 16 + 32 + NI;

    logic          Clk;
    logic          Reset;
    logic          ICacheMiss, DCacheMiss, LoadUse, BranchOrJump_E;
    logic [31:0]   PC_I;
    logic [NI-1:0] IrqReq, IrqMask;
    logic          IE, Eret;
    logic          Stall, InterruptHandled, Flush, InHandler;
    logic [31:0]   EPC;
    logic [NI-1:0] IrqCause;
    logic [CW-1:0] StallCycles;
    logic [1:0]    DbgState;

    fetch_irq_ctrl #(.NUM_IRQ(NI), .STALL_CNT_W(CW)) dut (
        .Clk(Clk), .Reset(Reset), .ICacheMiss(ICacheMiss), .DCacheMiss(DCacheMiss),
        .LoadUse(LoadUse), .BranchOrJump_E(BranchOrJump_E), .PC_I(PC_I),
        .IrqReq(IrqReq), .IrqMask(IrqMask), .IE(IE), .Eret(Eret),
        .Stall(Stall), .InterruptHandled(InterruptHandled), .Flush(Flush),
        .EPC(EPC), .IrqCause(IrqCause), .InHandler(InHandler),
        .StallCycles(StallCycles), .DbgState(DbgState)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic [EW-1:0] exp_q[$];
    logic [PW-1:0] pulse_q[$];
    int n_total = 0;
    int n_bad   = 0;
    bit mon_en  = 0;
    int cyc     = 0;
    int mon_cyc = 0;

    // Reference model: an interrupt is either absent, accepted-but-undelivered (possibly still
    // waiting for its delay slot), or being serviced.
    bit            m_accepted = 0;
    bit            m_slot     = 0;
    bit            m_serving  = 0;
    logic [31:0]   m_epc      = 32'd0;
    logic [NI-1:0] m_cause    = '0;
    int            m_cnt      = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, mon_cyc, act, req);
        end
    endtask

    task automatic step(input bit rst, input bit icm, input bit dcm, input bit lu, input bit bj,
                        input logic [31:0] pc, input logic [NI-1:0] req, input logic [NI-1:0] mask,
                        input bit ie, input bit eret);
        bit st, pend, pulse;
        @(posedge Clk);
        #1;
        Reset = rst; ICacheMiss = icm; DCacheMiss = dcm; LoadUse = lu; BranchOrJump_E = bj;
        PC_I = pc; IrqReq = req; IrqMask = mask; IE = ie; Eret = eret;
        st    = icm | dcm | lu;
        pend  = ie && ((req & mask) != '0);
        pulse = !rst && m_accepted && !m_slot && !st;
        exp_q.push_back({cyc[15:0], st, pulse, m_serving, m_epc, m_cause, m_cnt[CW-1:0]});
        if (pulse) pulse_q.push_back({cyc[15:0], pc, m_cause});
        mon_en = 1;
        if (rst) begin
            m_accepted = 0; m_slot = 0; m_serving = 0; m_epc = 32'd0; m_cause = '0; m_cnt = 0;
        end else begin
`ifdef FETCH_CTRL_PERF_EN
            if (st && m_cnt < (1 << CW) - 1) m_cnt++;
`endif
            if (m_serving) begin
                if (eret && !st) m_serving = 0;
            end else if (m_accepted) begin
                if (m_slot) begin
                    if (!st) m_slot = 0;
                end else if (!st) begin
                    m_accepted = 0; m_serving = 1; m_epc = pc;
                end
            end else if (pend) begin
                m_accepted = 1; m_slot = bj; m_cause = req & mask;
            end
        end
        cyc++;
    endtask

    always @(negedge Clk) begin
        logic [EW-1:0] e;
        logic [PW-1:0] p;
        if (mon_en && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("stall",        64'(Stall),            64'(e[EW-17]));
            chk("handled",      64'(InterruptHandled), 64'(e[EW-18]));
            chk("flush",        64'(Flush),            64'(e[EW-18]));
            chk("in_handler",   64'(InHandler),        64'(e[EW-19]));
            chk("epc",          64'(EPC),              64'(e[NI+CW+31:NI+CW]));
            chk("irq_cause",    64'(IrqCause),         64'(e[NI+CW-1:CW]));
            chk("stall_cycles", 64'(StallCycles),      64'(e[CW-1:0]));
            if (InterruptHandled) begin
                if (pulse_q.size() == 0) begin
                    chk("unexpected_pulse", 64'd1, 64'd0);
                end else begin
                    p = pulse_q.pop_front();
                    chk("pulse_cycle", 64'(mon_cyc), 64'(p[PW-1:PW-16]));
                    chk("pulse_cause", 64'(IrqCause), 64'(p[NI-1:0]));
                end
            end
            mon_cyc++;
        end
    end

    initial begin
        Reset = 1; ICacheMiss = 0; DCacheMiss = 0; LoadUse = 0; BranchOrJump_E = 0;
        PC_I = 32'd0; IrqReq = '0; IrqMask = '0; IE = 0; Eret = 0;
        repeat (3) @(posedge Clk);

        // Straight-line interrupt, then return.
        step(0, 0, 0, 0, 0, 32'h4000_0010, 4'b0010, 4'b1111, 1, 0);
        step(0, 0, 0, 0, 0, 32'h4000_0010, 4'b0010, 4'b1111, 1, 0);
        step(0, 0, 0, 0, 0, 32'h8000_0180, 4'b0000, 4'b1111, 1, 0);
        step(0, 0, 0, 0, 0, 32'h8000_0184, 4'b0000, 4'b1111, 1, 1);
        // Interrupt arriving with a branch in E.
        step(0, 0, 0, 0, 1, 32'h4000_00FC, 4'b0100, 4'b1111, 1, 0);
        step(0, 0, 0, 0, 0, 32'h4000_0100, 4'b0000, 4'b1111, 1, 0);
        step(0, 0, 0, 0, 0, 32'h4000_0100, 4'b0000, 4'b1111, 1, 0);
        // Line 3 raised inside the handler, then Eret releases it.
        step(0, 0, 0, 0, 0, 32'h8000_0180, 4'b1000, 4'b1111, 1, 0);
        step(0, 0, 0, 0, 0, 32'h8000_0184, 4'b1000, 4'b1111, 1, 1);
        step(0, 0, 0, 0, 0, 32'h4000_0104, 4'b1000, 4'b1111, 1, 0);
        step(0, 0, 0, 0, 0, 32'h4000_0108, 4'b1000, 4'b1111, 1, 0);
        step(0, 0, 0, 0, 0, 32'h8000_0180, 4'b0000, 4'b1111, 1, 1);
        // Stall held while the pulse is due.
        step(0, 0, 0, 0, 0, 32'h4000_0200, 4'b0001, 4'b0001, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 32'h4000_0200 + 32'(i), 4'b0001, 4'b0001, 1, 0);
        step(0, 0, 0, 0, 0, 32'h4000_0208, 4'b0001, 4'b0001, 1, 0);
        step(0, 0, 0, 0, 0, 32'h8000_0180, 4'b0000, 4'b0001, 1, 1);
        // Reset while waiting on a delay slot.
        step(0, 0, 0, 0, 1, 32'h4000_0300, 4'b0110, 4'b1111, 1, 0);
        step(1, 0, 0, 0, 0, 32'h4000_0304, 4'b0000, 4'b1111, 1, 0);
        step(0, 0, 0, 0, 0, 32'h4000_0308, 4'b0000, 4'b1111, 1, 0);
        // Long stall run to exercise counter saturation.
        for (int i = 0; i < 20; i++) step(0, 0, 1, 0, 0, 32'h4000_0400, 4'b0000, 4'b1111, 1, 0);

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 149) == 0,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom() & 32'hFFFF_FFFC,
                 NI'($urandom_range(0, 15)) & NI'($urandom_range(0, 15)),
                 NI'($urandom_range(0, 15)) | NI'($urandom_range(0, 15)),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0);
        end

        @(negedge Clk);
        #1;
        mon_en = 0;
        chk("pulse_queue_drained", 64'(pulse_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
